// File: rtl/serial_fa_sched.sv
// Bit-serial adder that time-shares one full-adder cell between two round-robin requesters.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN (adds sub0/sub1 inputs).
module serial_fa_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_SUB_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              win;
    logic              ptr;
    logic              owner;
    logic              carry;
    logic              sub_sel;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  b_load;
    logic [CW-1:0]     cnt;
    logic              fa_s;
    logic              fa_c;

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // The single shared full-adder cell, fed LSB first.
    always_comb begin
        {fa_c, fa_s} = full_add(op_a[0], op_b[0], carry);
    end

    // Next-state, arbitration and operand selection.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    if (req0 && req1) begin
                        win = ptr;
                    end else begin
                        win = req1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef SERIAL_SUB_EN
        sub_sel = win ? sub1 : sub0;
`else
        sub_sel = 1'b0;
`endif
        b_load = (win ? b1 : b0) ^ {WIDTH{sub_sel}};
    end

    // Datapath, handshake and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            carry   <= 1'b0;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            op_a    <= {WIDTH{1'b0}};
            op_b    <= {WIDTH{1'b0}};
            acc     <= {WIDTH{1'b0}};
            cnt     <= {CW{1'b0}};
        end else begin
            state <= state_nxt;
            ack0  <= accept & ~win;
            ack1  <= accept & win;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= win ? a1 : a0;
                        op_b  <= b_load;
                        carry <= sub_sel;
                        owner <= win;
                        ptr   <= ~win;
                        cnt   <= {CW{1'b0}};
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    carry <= fa_c;
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                end
                DONE: begin
                    done    <= 1'b1;
                    result  <= acc;
                    cout    <= carry;
                    done_id <= owner;
                    busy    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fa_sched.sv
// Self-checking bench for serial_fa_sched: event-time model checked every cycle plus literal vectors.
module tb_serial_fa_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
`ifdef SERIAL_SUB_EN
    logic         sub0 = 1'b0;
    logic         sub1 = 1'b0;
`endif
    logic         ack0, ack1, busy, done, done_id, cout;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    serial_fa_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
`ifdef SERIAL_SUB_EN
        .sub0(sub0), .sub1(sub1),
`endif
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
        .done_id(done_id), .result(result), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: the operation is scheduled in edge numbers, the sum comes from plain arithmetic.
    int           cyc = 0;
    int           next_free = 0;
    int           done_edge = 0;
    bit           pending = 0;
    bit           m_ptr = 0;
    bit           m_id = 0;
    bit           m_sub;
    logic [W:0]   m_full = '0;
    bit           chk_en = 0;
    logic         exp_ack0 = 0, exp_ack1 = 0, exp_busy = 0, exp_done = 0, exp_id = 0, exp_cout = 0;
    logic [W-1:0] exp_res = '0;

    always @(posedge clk) begin
        cyc++;
        exp_ack0 = 0;
        exp_ack1 = 0;
        exp_done = 0;
        if (rst) begin
            exp_busy = 0; exp_id = 0; exp_res = '0; exp_cout = 0;
            pending = 0; m_ptr = 0; next_free = cyc;
            chk_en = 1;
        end else begin
            if (pending && cyc == done_edge) begin
                exp_done = 1; exp_res = m_full[W-1:0]; exp_cout = m_full[W];
                exp_id = m_id; exp_busy = 0; pending = 0;
            end
            if (cyc >= next_free && (req0 || req1)) begin
                m_id  = (req0 && req1) ? m_ptr : req1;
                m_ptr = !m_id;
`ifdef SERIAL_SUB_EN
                m_sub = m_id ? sub1 : sub0;
`else
                m_sub = 0;
`endif
                if (m_sub)
                    m_full = {1'b0, (m_id ? a1 : a0)} + {1'b0, ~(m_id ? b1 : b0)} + (W+1)'(1);
                else
                    m_full = {1'b0, (m_id ? a1 : a0)} + {1'b0, (m_id ? b1 : b0)};
                exp_ack0 = !m_id; exp_ack1 = m_id; exp_busy = 1; pending = 1;
                done_edge = cyc + W + 1;
                next_free = cyc + W + 2;
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack0", 32'(ack0), 32'(exp_ack0));
            chk("ack1", 32'(ack1), 32'(exp_ack1));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("done_id", 32'(done_id), 32'(exp_id));
            chk("result", 32'(result), 32'(exp_res));
            chk("cout", 32'(cout), 32'(exp_cout));
            chk("ack_excl", 32'(ack0 & ack1), 32'(0));
        end
    end

    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                          input logic [W-1:0] er, input bit ec);
        int ka;
        int kd;
        ka = -1;
        kd = -1;
        @(negedge clk);
        if (id) begin req1 = 1; a1 = a; b1 = b; end
        else    begin req0 = 1; a0 = a; b0 = b; end
`ifdef SERIAL_SUB_EN
        if (id) sub1 = sub; else sub0 = sub;
`else
        if (sub) $display("note: subtract vector skipped in add-only build");
`endif
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ka < 0 && (id ? ack1 : ack0)) begin
                ka = k;
                req0 = 0;
                req1 = 0;
            end
            if (done) begin
                kd = k;
                break;
            end
        end
        chk("ack_seen", 32'(ka >= 0), 32'(1));
        chk("done_latency", 32'(kd - ka), 32'(W + 1));
        chk("lit_result", 32'(result), 32'(er));
        chk("lit_cout", 32'(cout), 32'(ec));
        chk("lit_done_id", 32'(done_id), 32'(id));
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1;
        repeat (n) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int t0, t1, nd;
        bit id_first, id_second;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        rst = 0;

        run_op(0, 8'h3C, 8'h05, 0, 8'h41, 0);
        run_op(1, 8'hFF, 8'h01, 0, 8'h00, 1);
        run_op(0, 8'h80, 8'h80, 0, 8'h00, 1);
        run_op(1, 8'h7F, 8'h01, 0, 8'h80, 0);

        // Both requesters from reset: 0 first, then 1, acks ten cycles apart.
        do_reset(2);
        @(negedge clk);
        req0 = 1; a0 = 8'h12; b0 = 8'h34;
        req1 = 1; a1 = 8'hF0; b1 = 8'h20;
        t0 = -1; t1 = -1; nd = 0; id_first = 0; id_second = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ack0) begin t0 = k; req0 = 0; end
            if (ack1) begin t1 = k; req1 = 0; end
            if (done) begin
                if (nd == 0) id_first = done_id; else id_second = done_id;
                nd++;
                if (nd == 2) break;
            end
        end
        chk("rr_ack_gap", 32'(t1 - t0), 32'(10));
        chk("rr_done_cnt", 32'(nd), 32'(2));
        chk("rr_first_id", 32'(id_first), 32'(0));
        chk("rr_second_id", 32'(id_second), 32'(1));
        chk("rr_last_result", 32'(result), 32'(8'h10));
        chk("rr_last_cout", 32'(cout), 32'(1));

        // Reset on the 4th RUN cycle aborts the operation.
        @(negedge clk);
        req0 = 1; a0 = 8'hAA; b0 = 8'h55;
        t0 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack0) begin t0 = k; req0 = 0; break; end
        end
        chk("abort_ack_seen", 32'(t0 >= 0), 32'(1));
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        rst = 0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'(0));

        // Reset wins over a simultaneous request.
        @(negedge clk);
        rst = 1; req1 = 1; a1 = 8'h01; b1 = 8'h02;
        @(negedge clk);
        chk("rst_prio_ack1", 32'(ack1), 32'(0));
        rst = 0; req1 = 0;
        @(negedge clk);

`ifdef SERIAL_SUB_EN
        run_op(0, 8'h05, 8'h07, 1, 8'hFE, 0);
        run_op(0, 8'h07, 8'h05, 1, 8'h02, 1);
        sub0 = 0;
`endif
        run_op(0, 8'h01, 8'h01, 0, 8'h02, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
